stack_ptr_unit: RTL

Parametrised stack pointer register for the CPU datapath; successor to the fixed 16-bit inc/dec SP. The stack grows downward from TOP to BOTTOM. The block adds a configurable step, a direct load, full/empty status, a depth output, and sticky overflow/underflow/range error flags. The control unit drives push (dec), pop (inc) and load; `out` feeds the address mux.

---
 rtl/stack_ptr_if.sv | 29 ++
 rtl/stack_ptr_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/stack_ptr_if.sv
// Stack pointer control/status bundle between the control unit and the SP.
interface stack_ptr_if #(
  parameter int unsigned WIDTH = 16
);
  logic             inc;
  logic             dec;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             clr_err;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] depth;
  logic             ovf;
  logic             unf;
  logic             rng_err;

  // Control unit side: issues commands, observes pointer and status.
  modport master (
    output inc, dec, ld, ld_val, clr_err,
    input  out, empty, full, depth, ovf, unf, rng_err
  );

  // Stack pointer side.
  modport slave (
    input  inc, dec, ld, ld_val, clr_err,
    output out, empty, full, depth, ovf, unf, rng_err
  );
endinterface

// File: rtl/stack_ptr_unit.sv
// Downward-growing stack pointer with configurable step, direct load,
// full/empty/depth status and sticky overflow/underflow/range flags.
module stack_ptr_unit #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] TOP    = 16'h01FF,
  parameter logic [WIDTH-1:0] BOTTOM = 16'h0100,
  parameter int unsigned      STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  stack_ptr_if.slave  bus
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Reject configurations that would let the pointer leave the legal,
  // step-aligned window.
  if (BOTTOM > TOP) begin : g_bad_range
    $fatal(1, "stack_ptr_unit: BOTTOM must not exceed TOP");
  end
  if (STEP < 1) begin : g_bad_step
    $fatal(1, "stack_ptr_unit: STEP must be at least 1");
  end else if (((TOP - BOTTOM) % STEP_W) != '0) begin : g_bad_align
    $fatal(1, "stack_ptr_unit: TOP-BOTTOM must be a multiple of STEP");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rng_err_q, rng_err_d;

  logic             is_empty;
  logic             is_full;
  logic             ld_ok;
  logic             ovf_evt;
  logic             unf_evt;
  logic             rng_evt;

  // The pointer is always step-aligned inside [BOTTOM, TOP], so "out <= TOP-STEP"
  // is exactly "not empty" and "out >= BOTTOM+STEP" is exactly "not full";
  // equality compares also avoid wrap in TOP-STEP / BOTTOM+STEP at the extremes.
  assign is_empty = (out_q == TOP);
  assign is_full  = (out_q == BOTTOM);
  assign ld_ok    = (bus.ld_val >= BOTTOM) && (bus.ld_val <= TOP) &&
                    (((TOP - bus.ld_val) % STEP_W) == '0);

  // Next pointer and error events: ld wins over inc/dec; inc+dec is a no-op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    out_d   = out_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    rng_evt = 1'b0;
    if (bus.ld) begin
      if (ld_ok) out_d   = bus.ld_val;
      else       rng_evt = 1'b1;
    end else if (bus.inc && !bus.dec) begin
      if (!is_empty) out_d   = out_q + STEP_W;
      else           unf_evt = 1'b1;
    end else if (bus.dec && !bus.inc) begin
      if (!is_full) out_d   = out_q - STEP_W;
      else          ovf_evt = 1'b1;
    end
  end

  // Sticky flags: a new event in the same cycle beats clr_err.
  always_comb begin
    ovf_d     = (ovf_q     && !bus.clr_err) || ovf_evt;
    unf_d     = (unf_q     && !bus.clr_err) || unf_evt;
    rng_err_d = (rng_err_q && !bus.clr_err) || rng_evt;
  end

  // State registers with synchronous reset overriding every command.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      out_q     <= TOP;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rng_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rng_err_q <= rng_err_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.depth   = (TOP - out_q) / STEP_W;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.rng_err = rng_err_q;

endmodule
